// File: rtl/run_monitor_pkg.sv
// Shared types and default parameter values for the run monitor.
package run_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_XLEN      = 32;
    localparam int DEF_NUM_END   = 2;
    localparam int DEF_NUM_CHECK = 4;
    localparam int DEF_TIMEOUT   = 50000;
    localparam int DEF_STALL_CYC = 4;

endpackage

// File: rtl/run_monitor_end_pc_matcher.sv
// Combinational priority match of the current PC against the end-address table.
// The lowest-numbered matching entry wins.
module end_pc_matcher #(
    parameter int XLEN    = 32,
    parameter int NUM_END = 2
) (
    input  logic [XLEN-1:0]         pc,
    input  logic [NUM_END*XLEN-1:0] end_pc,
    output logic                    hit,
    output logic [$clog2(NUM_END+1)-1:0] idx
);
    localparam int IDXW = $clog2(NUM_END + 1);

    logic [NUM_END-1:0] match_s;

    // Scan from the highest entry down so the lowest matching index is the last one written.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_END - 1; i >= 0; i--) begin
            match_s[i] = (pc == end_pc[i*XLEN +: XLEN]);
            hit        = hit | match_s[i];
            idx        = match_s[i] ? IDXW'(i) : idx;
        end
    end

endmodule

// File: rtl/run_monitor.sv
// Run monitor: watches the processor PC for an end address, a self-loop stall or a
// timeout, then walks the register checks through the debug read port and reports.
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int XLEN      = DEF_XLEN,
    parameter int NUM_END   = DEF_NUM_END,
    parameter int NUM_CHECK = DEF_NUM_CHECK,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int STALL_CYC = DEF_STALL_CYC
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [XLEN-1:0]                pc,
    input  logic [NUM_END*XLEN-1:0]        end_pc,
    input  logic [NUM_CHECK-1:0]           chk_en,
    input  logic [NUM_CHECK*5-1:0]         chk_reg,
    input  logic [NUM_CHECK*XLEN-1:0]      chk_exp,
    output logic [4:0]                     rf_raddr,
    input  logic [XLEN-1:0]                rf_rdata,
    output logic                           busy,
    output logic                           done,
    output logic                           pass,
    output logic                           timeout,
    output logic [$clog2(NUM_END+1)-1:0]   end_idx,
    output logic [NUM_CHECK-1:0]           fail_mask,
    output logic [31:0]                    cycles,
    output logic [XLEN-1:0]                final_pc
);
    localparam int IDXW = $clog2(NUM_END + 1);
    localparam int CIW  = (NUM_CHECK > 1) ? $clog2(NUM_CHECK) : 1;
    localparam int SCW  = $clog2(STALL_CYC + 1);

    state_t                state_r;
    logic [CIW-1:0]        chk_idx_r;
    logic [SCW-1:0]        stall_cnt_r;
    logic [XLEN-1:0]       last_pc_r;

    logic                  hit_s;
    logic [IDXW-1:0]       hit_idx_s;
    logic [31:0]           cycles_next_s;
    logic [SCW-1:0]        stall_next_s;
    logic                  stall_s;
    logic                  timeout_s;
    logic                  last_chk_s;
    logic [CIW-1:0]        next_idx_s;
    logic [4:0]            next_reg_s;
    logic [XLEN-1:0]       exp_s;
    logic                  mismatch_s;
    logic [NUM_CHECK-1:0]  fail_next_s;

    end_pc_matcher #(
        .XLEN    (XLEN),
        .NUM_END (NUM_END)
    ) u_end_pc_matcher (
        .pc     (pc),
        .end_pc (end_pc),
        .hit    (hit_s),
        .idx    (hit_idx_s)
    );

    // Next-value terms for the RUN and CHECK phases.
    always_comb begin
        cycles_next_s = (cycles == 32'hFFFF_FFFF) ? cycles : (cycles + 32'd1);
        // A zero count means no PC has been sampled yet in this run.
        stall_next_s  = ((stall_cnt_r != '0) && (pc == last_pc_r)) ? (stall_cnt_r + SCW'(1)) : SCW'(1);
        stall_s       = (stall_next_s >= SCW'(STALL_CYC));
        timeout_s     = (cycles_next_s >= 32'(TIMEOUT));
        last_chk_s    = (chk_idx_r == CIW'(NUM_CHECK - 1));
        next_idx_s    = last_chk_s ? '0 : (chk_idx_r + CIW'(1));
        next_reg_s    = chk_reg[32'(next_idx_s)*5 +: 5];
        exp_s         = chk_exp[32'(chk_idx_r)*XLEN +: XLEN];
        mismatch_s    = chk_en[chk_idx_r] && (rf_rdata != exp_s);
        fail_next_s   = fail_mask | (mismatch_s ? (NUM_CHECK'(1) << chk_idx_r) : '0);
    end

    // Control FSM with all result outputs held in registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            chk_idx_r   <= '0;
            stall_cnt_r <= '0;
            last_pc_r   <= '0;
            rf_raddr    <= 5'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            end_idx     <= '0;
            fail_mask   <= '0;
            cycles      <= 32'd0;
            final_pc    <= '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r     <= ST_RUN;
                        chk_idx_r   <= '0;
                        stall_cnt_r <= '0;
                        last_pc_r   <= '0;
                        rf_raddr    <= 5'd0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        timeout     <= 1'b0;
                        end_idx     <= '0;
                        fail_mask   <= '0;
                        cycles      <= 32'd0;
                        final_pc    <= '0;
                    end
                end
                ST_RUN: begin
                    cycles      <= cycles_next_s;
                    stall_cnt_r <= stall_next_s;
                    last_pc_r   <= pc;
                    if (hit_s) begin
                        state_r   <= ST_CHECK;
                        end_idx   <= hit_idx_s;
                        final_pc  <= pc;
                        chk_idx_r <= '0;
                        rf_raddr  <= chk_reg[4:0];
                    end else if (stall_s) begin
                        state_r   <= ST_CHECK;
                        end_idx   <= IDXW'(NUM_END);
                        final_pc  <= pc;
                        chk_idx_r <= '0;
                        rf_raddr  <= chk_reg[4:0];
                    end else if (timeout_s) begin
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    fail_mask <= fail_next_s;
                    chk_idx_r <= next_idx_s;
                    if (last_chk_s) begin
                        state_r  <= ST_DONE;
                        rf_raddr <= 5'd0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        pass     <= (fail_next_s == '0);
                    end else begin
                        rf_raddr <= next_reg_s;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    rf_raddr <= 5'd0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    pass     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_monitor.sv
// Self-checking bench for run_monitor: table of runs scored through an expected-result
// queue, plus hand-written sequences for reset during CHECK and DONE hold.
module tb_run_monitor;
    localparam int XLEN      = 32;
    localparam int NUM_END   = 2;
    localparam int NUM_CHECK = 4;
    localparam int TIMEOUT   = 100;
    localparam int STALL_CYC = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [31:0]  pc;
    logic [63:0]  end_pc;
    logic [3:0]   chk_en;
    logic [19:0]  chk_reg;
    logic [127:0] chk_exp;
    logic [4:0]   rf_raddr;
    logic [31:0]  rf_rdata;
    logic         busy, done, pass, timeout;
    logic [1:0]   end_idx;
    logic [3:0]   fail_mask;
    logic [31:0]  cycles;
    logic [31:0]  final_pc;

    logic [31:0]  rf_mem [32];
    assign rf_rdata = rf_mem[rf_raddr];

    always #5 clk = ~clk;

    run_monitor #(
        .XLEN(XLEN), .NUM_END(NUM_END), .NUM_CHECK(NUM_CHECK),
        .TIMEOUT(TIMEOUT), .STALL_CYC(STALL_CYC)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pc(pc), .end_pc(end_pc),
        .chk_en(chk_en), .chk_reg(chk_reg), .chk_exp(chk_exp),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .busy(busy), .done(done),
        .pass(pass), .timeout(timeout), .end_idx(end_idx), .fail_mask(fail_mask),
        .cycles(cycles), .final_pc(final_pc)
    );

    // n == 0: pc never reaches tgt (timeout run); otherwise tgt appears on RUN cycle n and is held.
    typedef struct {
        int           n;
        logic [31:0]  tgt;
        logic [63:0]  endv;
        logic [3:0]   en;
        logic [127:0] exp;
        logic [31:0]  rf10;
        logic         e_pass;
        logic         e_to;
        logic [1:0]   e_idx;
        logic [3:0]   e_fm;
        logic [31:0]  e_cyc;
        logic [31:0]  e_fpc;
    } vec_t;

    typedef struct {
        logic        pass;
        logic        to;
        logic [1:0]  idx;
        logic [3:0]  fm;
        logic [31:0] cyc;
        logic [31:0] fpc;
    } res_t;

    localparam logic [31:0]  G    = 32'h00ff_f05f;
    localparam logic [63:0]  E    = {32'h0000_0100, 32'h0000_00bc};
    localparam logic [127:0] GOOD = {32'h0000_0033, 32'h0000_0022, 32'h0000_0011, 32'h00ff_f05f};
    localparam logic [127:0] BAD  = {32'h0000_0034, 32'h0000_0bad, 32'h0000_0011, 32'h00ff_f05f};

    vec_t vecs [9];
    res_t sb_q [$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pc_for(input vec_t v, input int k);
        if (v.n == 0 || k < v.n) return 32'h0000_1000 + 32'(4 * k);
        return v.tgt;
    endfunction

    task automatic setup(input vec_t v);
        end_pc      = v.endv;
        chk_en      = v.en;
        chk_exp     = v.exp;
        rf_mem[10]  = v.rf10;
    endtask

    task automatic run_vec(input int id, input vec_t v);
        res_t r;
        res_t e;
        bit   seen;
        setup(v);
        r.pass = v.e_pass; r.to = v.e_to; r.idx = v.e_idx;
        r.fm = v.e_fm; r.cyc = v.e_cyc; r.fpc = v.e_fpc;
        sb_q.push_back(r);
        start = 1'b1;
        step();
        start = 1'b0;
        chk($sformatf("v%0d start_busy", id), 32'(busy), 32'd1);
        chk($sformatf("v%0d start_clear", id), {27'd0, done, fail_mask}, 32'd0);
        chk($sformatf("v%0d start_cycles", id), cycles, 32'd0);
        seen = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            pc = pc_for(v, k);
            step();
            if (k == 1) chk($sformatf("v%0d raddr_run", id), 32'(rf_raddr), 32'd0);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        e = sb_q.pop_front();
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL v%0d done_wait: got no done expected done within 400 cycles", id);
        end else begin
            chk($sformatf("v%0d pass", id), 32'(pass), 32'(e.pass));
            chk($sformatf("v%0d timeout", id), 32'(timeout), 32'(e.to));
            chk($sformatf("v%0d end_idx", id), 32'(end_idx), 32'(e.idx));
            chk($sformatf("v%0d fail_mask", id), 32'(fail_mask), 32'(e.fm));
            chk($sformatf("v%0d cycles", id), cycles, e.cyc);
            chk($sformatf("v%0d final_pc", id), final_pc, e.fpc);
            chk($sformatf("v%0d busy_done", id), 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'd0;
        rf_mem[1] = 32'h11;
        rf_mem[2] = 32'h22;
        rf_mem[3] = 32'h33;
        chk_reg = {5'd3, 5'd2, 5'd1, 5'd10};
        start   = 1'b0;
        pc      = 32'd0;
        end_pc  = E;
        chk_en  = 4'b0001;
        chk_exp = GOOD;

        //            n    tgt    endv                          en       exp   rf10   pass to idx fm       cyc  fpc
        vecs[0] = '{ 40, 32'hbc, E,                            4'b0001, GOOD, G,     1'b1, 1'b0, 2'd0, 4'b0000, 32'd40,  32'hbc};
        vecs[1] = '{ 40, 32'hbc, E,                            4'b0001, GOOD, 32'd0, 1'b0, 1'b0, 2'd0, 4'b0001, 32'd40,  32'hbc};
        vecs[2] = '{  0, 32'h0,  E,                            4'b0001, GOOD, G,     1'b0, 1'b1, 2'd0, 4'b0000, 32'd100, 32'h0};
        vecs[3] = '{  5, 32'h44, E,                            4'b0001, GOOD, G,     1'b1, 1'b0, 2'd2, 4'b0000, 32'd8,   32'h44};
        vecs[4] = '{100, 32'hbc, E,                            4'b0001, GOOD, G,     1'b1, 1'b0, 2'd0, 4'b0000, 32'd100, 32'hbc};
        vecs[5] = '{ 10, 32'h100, E,                           4'b0001, GOOD, G,     1'b1, 1'b0, 2'd1, 4'b0000, 32'd10,  32'h100};
        vecs[6] = '{ 12, 32'h200, {32'h200, 32'h200},          4'b0001, GOOD, G,     1'b1, 1'b0, 2'd0, 4'b0000, 32'd12,  32'h200};
        vecs[7] = '{ 20, 32'hbc, E,                            4'b1011, BAD,  G,     1'b0, 1'b0, 2'd0, 4'b1000, 32'd20,  32'hbc};
        vecs[8] = '{  7, 32'hbc, E,                            4'b1111, GOOD, G,     1'b1, 1'b0, 2'd0, 4'b0000, 32'd7,   32'hbc};

        // Power-on reset.
        reset = 1'b1;
        step();
        step();
        chk("reset_flags", {27'd0, busy, done, pass, timeout, 1'b0}, 32'd0);
        chk("reset_results", {18'd0, end_idx, fail_mask, rf_raddr, 3'd0}, 32'd0);
        chk("reset_cycles", cycles, 32'd0);
        reset = 1'b0;
        step();
        step();
        chk("idle_after_reset", {30'd0, busy, done}, 32'd0);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // DONE holds its results while start stays low.
        pc = 32'h0000_0bbb;
        step();
        step();
        step();
        chk("hold_done", 32'(done), 32'd1);
        chk("hold_cycles", cycles, 32'd7);
        chk("hold_pass", 32'(pass), 32'd1);

        // Reset while CHECK is on index 2.
        setup(vecs[0]);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            pc = pc_for(vecs[0], k);
            step();
        end
        chk("chk_raddr0", 32'(rf_raddr), 32'd10);
        step();
        chk("chk_raddr1", 32'(rf_raddr), 32'd1);
        step();
        chk("chk_raddr2", 32'(rf_raddr), 32'd2);
        chk("chk_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_flags", {27'd0, busy, done, pass, timeout, 1'b0}, 32'd0);
        chk("midreset_results", {18'd0, end_idx, fail_mask, rf_raddr, 3'd0}, 32'd0);
        chk("midreset_cycles", cycles, 32'd0);
        chk("midreset_final_pc", final_pc, 32'd0);
        step();
        reset = 1'b0;
        step();
        step();
        chk("idle_after_midreset", {30'd0, busy, done}, 32'd0);

        // Fresh run after the mid-CHECK reset.
        run_vec(9, vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/run_monitor.md
RUN_MONITOR -- requirements
Module: run_monitor

Interface
REQ-001 Parameter XLEN, 32, datapath/PC width.
REQ-002 Parameter NUM_END, 2, number of end-of-program PC addresses.
REQ-003 Parameter NUM_CHECK, 4, number of register checks per run.
REQ-004 Parameter TIMEOUT, 50000, max RUN cycles before timeout.
REQ-005 Parameter STALL_CYC, 4, consecutive unchanged-PC cycles treated as self-loop end.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  pulse; begins a run from IDLE or DONE.
REQ-009 pc  in  XLEN  processor PC, sampled each clk.
REQ-010 end_pc  in  NUM_END*XLEN  end addresses, entry i at bits [i*XLEN +: XLEN].
REQ-011 chk_en  in  NUM_CHECK  per-check enable.
REQ-012 chk_reg  in  NUM_CHECK*5  register index per check.
REQ-013 chk_exp  in  NUM_CHECK*XLEN  expected value per check.
REQ-014 rf_raddr  out  5  register-file debug read address.
REQ-015 rf_rdata  in  XLEN  combinational read data for rf_raddr, same cycle.
REQ-016 busy  out  1  high in RUN or CHECK.
REQ-017 done  out  1  high in DONE.
REQ-018 pass  out  1  valid when done: no timeout and fail_mask==0.
REQ-019 timeout  out  1  run ended by TIMEOUT.
REQ-020 end_idx  out  $clog2(NUM_END+1)  matched entry; NUM_END = stall end.
REQ-021 fail_mask  out  NUM_CHECK  bit i set on enabled check i mismatch.
REQ-022 cycles  out  32  RUN cycles counted.
REQ-023 final_pc  out  XLEN  pc captured at end detection.

Function
REQ-024 FSM states IDLE, RUN, CHECK, DONE; start in IDLE/DONE clears all result outputs and enters RUN next cycle; start in RUN/CHECK ignored.
REQ-025 RUN: cycles increments by 1 every cycle, saturating at 2^32-1.
REQ-026 RUN: pc equal to any end_pc entry -> CHECK; lowest matching index wins, stored in end_idx, pc stored in final_pc.
REQ-027 RUN: pc unchanged for STALL_CYC consecutive cycles with no match -> CHECK, end_idx=NUM_END.
REQ-028 RUN: cycles reaching TIMEOUT with no end/stall -> DONE, timeout=1, fail_mask=0, no CHECK.
REQ-029 Same-cycle end match and timeout: end match wins, timeout=0.
REQ-030 CHECK: one check per cycle, index 0..NUM_CHECK-1; rf_raddr=chk_reg[idx]; mismatch with chk_en[idx]=1 sets fail_mask[idx]; disabled checks consume a cycle, never fail; CHECK lasts exactly NUM_CHECK cycles.
REQ-031 rf_raddr = 0 outside CHECK.
REQ-032 DONE holds all results stable until start or reset.
REQ-033 pass = done & ~timeout & (fail_mask==0); pass=0 outside DONE.

Reset
REQ-034 reset asserted: state IDLE, all outputs 0, stall counter 0, within the same cycle (asynchronous), including mid-RUN or mid-CHECK.
REQ-035 After reset deassertion, block idle until start.

Structure
REQ-036 Package run_monitor_pkg holds state enum and default parameter constants.
REQ-037 Sub-module end_pc_matcher: combinational priority match of pc against end_pc, outputs hit and index.

Verification
REQ-038 end_pc={0x100,0xbc}, pc reaches 0xbc after 40 cycles, check x10 exp 0x00fff05f, rf returns 0x00fff05f -> done, pass=1, end_idx=0, final_pc=0xbc, cycles=40.
REQ-039 Same, rf returns 0x00000000 for x10 -> pass=0, fail_mask[0]=1.
REQ-040 TIMEOUT=100, pc never matches or stalls -> done after 100 RUN cycles, timeout=1, pass=0.
REQ-041 pc held at 0x44 for STALL_CYC cycles -> end_idx=NUM_END, final_pc=0x44.
REQ-042 pc matches end_pc on cycle TIMEOUT -> timeout=0, CHECK entered.
REQ-043 reset asserted during CHECK index 2 -> all outputs 0 immediately, state IDLE; fresh start completes normally.
